// File: rtl/teclado_escaner_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner:
// FSM state encoding, column drive patterns and the row/column to hex key map.
package teclado_pkg;

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      WAIT_REL  = 2'd3
   } teclado_state_t;

   localparam logic [3:0] COL_0    = 4'b1110;
   localparam logic [3:0] COL_1    = 4'b1101;
   localparam logic [3:0] COL_2    = 4'b1011;
   localparam logic [3:0] COL_3    = 4'b0111;
   localparam logic [3:0] FIL_IDLE = 4'hF;

   function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
      logic [3:0] pattern;
      case (col_idx)
         2'd0:    pattern = COL_0;
         2'd1:    pattern = COL_1;
         2'd2:    pattern = COL_2;
         default: pattern = COL_3;
      endcase
      return pattern;
   endfunction

   // Lowest-index row that is pulled low; only meaningful when fil_v != FIL_IDLE.
   function automatic logic [1:0] low_row(input logic [3:0] fil_v);
      logic [1:0] idx;
      casez (fil_v)
         4'b???0: idx = 2'd0;
         4'b??01: idx = 2'd1;
         4'b?011: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/teclado_escaner_if.sv
// Key event bus from the keypad scanner to the operand-assembly logic downstream.
interface teclado_escaner_if;

   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   modport master (
      output key_valid,
      output key_code,
      output key_held
   );

   modport slave (
      input key_valid,
      input key_code,
      input key_held
   );

endinterface

// File: rtl/teclado_escaner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so that
// idle active-low lines read as inactive straight out of reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/teclado_escaner.sv
// 4x4 keypad scanner: rotates the active-low columns, debounces press and
// release on the latched row, and emits one key_valid pulse per physical press.
module teclado_escaner
   import teclado_pkg::*;
#(
   parameter int SCAN_DIV     = 50_000,
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         fil,
   output logic [3:0]         col,
   teclado_escaner_if.master  key_if
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);

   logic [3:0]     fil_s;

   teclado_state_t state,       state_n;
   logic [DW-1:0]  dwell_cnt,   dwell_n;
   logic [CW-1:0]  deb_cnt,     deb_n;
   logic [1:0]     col_idx,     col_idx_n;
   logic [1:0]     row_idx,     row_idx_n;
   logic [3:0]     key_code_r,  key_code_n;
   logic           key_valid_r, key_valid_n;
   logic           key_held_r,  key_held_n;

   sync_2ff #(
      .WIDTH (4)
   ) u_sync_fil (
      .clk (clk),
      .rst (rst),
      .d   (fil),
      .q   (fil_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= SCAN;
         dwell_cnt   <= '0;
         deb_cnt     <= '0;
         col_idx     <= 2'd0;
         row_idx     <= 2'd0;
         key_code_r  <= 4'h0;
         key_valid_r <= 1'b0;
         key_held_r  <= 1'b0;
      end else begin
         state       <= state_n;
         dwell_cnt   <= dwell_n;
         deb_cnt     <= deb_n;
         col_idx     <= col_idx_n;
         row_idx     <= row_idx_n;
         key_code_r  <= key_code_n;
         key_valid_r <= key_valid_n;
         key_held_r  <= key_held_n;
      end
   end

   // Outputs are computed for the next state and registered, so key_valid
   // and key_held have no combinational path from the keypad rows.
   always_comb begin
      state_n     = state;
      dwell_n     = dwell_cnt;
      deb_n       = deb_cnt;
      col_idx_n   = col_idx;
      row_idx_n   = row_idx;
      key_code_n  = key_code_r;
      key_valid_n = 1'b0;
      key_held_n  = 1'b0;

      case (state)
         SCAN: begin
            if (dwell_cnt == DWELL_LAST) begin
               dwell_n = '0;
               if (fil_s != FIL_IDLE) begin
                  row_idx_n = low_row(fil_s);
                  deb_n     = '0;
                  state_n   = DEB_PRESS;
               end else begin
                  col_idx_n = col_idx + 2'd1;
               end
            end else begin
               dwell_n = dwell_cnt + 1'b1;
            end
         end

         DEB_PRESS: begin
            if (fil_s[row_idx]) begin
               deb_n     = '0;
               dwell_n   = '0;
               col_idx_n = col_idx + 2'd1;
               state_n   = SCAN;
            end else if (deb_cnt == DEB_LAST) begin
               deb_n       = '0;
               key_valid_n = 1'b1;
               key_held_n  = 1'b1;
               key_code_n  = key_map(row_idx, col_idx);
               state_n     = PRESSED;
            end else begin
               deb_n = deb_cnt + 1'b1;
            end
         end

         PRESSED: begin
            key_held_n = 1'b1;
            state_n    = WAIT_REL;
         end

         // Release must be stable for the full debounce window; any low sample restarts it.
         WAIT_REL: begin
            key_held_n = 1'b1;
            if (!fil_s[row_idx]) begin
               deb_n = '0;
            end else if (deb_cnt == DEB_LAST) begin
               deb_n      = '0;
               key_held_n = 1'b0;
               dwell_n    = '0;
               col_idx_n  = col_idx + 2'd1;
               state_n    = SCAN;
            end else begin
               deb_n = deb_cnt + 1'b1;
            end
         end

         default: begin
            state_n = SCAN;
         end
      endcase
   end

   assign col              = col_drive(col_idx);
   assign key_if.key_valid = key_valid_r;
   assign key_if.key_code  = key_code_r;
   assign key_if.key_held  = key_held_r;

endmodule

// File: tb/tb_teclado_escaner.sv
// Bench for teclado_escaner: a keypad model pulls rows low for pressed keys on
// the driven column; expected codes and timing come from the keypad rules.
module tb_teclado_escaner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CYC = 8;
   localparam int LAT_MIN      = DEBOUNCE_CYC + 1;
   localparam int LAT_MAX      = 5 * SCAN_DIV + DEBOUNCE_CYC + 6;
   localparam int WAIT_BUDGET  = 60;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  fil;
   logic [3:0]  col;
   logic [15:0] keys = '0;

   int          total = 0;
   int          bad = 0;
   int          pulse_cnt = 0;
   int          wide_cnt = 0;
   logic        prev_valid = 1'b0;
   logic [3:0]  last_code = 4'h0;

   // Key index is row*4 + column.
   logic [3:0]  code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'hE, 4'h0, 4'hF, 4'hD};

   teclado_escaner_if kif ();

   teclado_escaner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .fil    (fil),
      .col    (col),
      .key_if (kif)
   );

   always #5 clk = ~clk;

   always_comb begin
      fil = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) fil[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (kif.key_valid) begin
         pulse_cnt = pulse_cnt + 1;
         last_code = kif.key_code;
         if (prev_valid) wide_cnt = wide_cnt + 1;
      end
      prev_valid = kif.key_valid;
   end

   function automatic logic [3:0] colOf(input int i);
      logic [3:0] v;
      v = 4'b0001 << i;
      return ~v;
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int k, input bit press);
      keys[k] = press;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkRange(input string tag, input int val, input int lo, input int hi);
      total++;
      assert (val >= lo && val <= hi) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
      end
   endtask

   task automatic waitPulse(input int start_cnt, output int lat);
      lat = 0;
      while (pulse_cnt == start_cnt && lat < WAIT_BUDGET) begin
         step(1);
         lat++;
      end
   endtask

   task automatic pressKey(input int k, input string tag);
      int base;
      int lat;
      base = pulse_cnt;
      applyStimulus(k, 1'b1);
      waitPulse(base, lat);
      checkOutput({tag, "_pulse"}, pulse_cnt, base + 1);
      checkRange({tag, "_lat"}, lat, LAT_MIN, LAT_MAX);
      checkOutput({tag, "_code"}, last_code, code_tab[k]);
      step($urandom_range(5, 25));
      checkOutput({tag, "_held"}, kif.key_held, 1);
      checkOutput({tag, "_single"}, pulse_cnt, base + 1);
      applyStimulus(k, 1'b0);
      step(DEBOUNCE_CYC + 1);
      checkOutput({tag, "_held_pre_rel"}, kif.key_held, 1);
      step(1);
      checkOutput({tag, "_released"}, kif.key_held, 0);
      checkOutput({tag, "_resume_col"}, col, colOf(((k % 4) + 1) % 4));
      checkOutput({tag, "_code_kept"}, kif.key_code, code_tab[k]);
      step(6);
   endtask

   initial begin
      int base;
      int lat;
      int k;
      int seq [7] = '{4, 5, 13, 8, 14, 12, 15};

      // Reset state and free-running column rotation.
      rst = 1'b0;
      step(8);
      checkOutput("rst_col", col, 4'b1110);
      checkOutput("rst_valid", kif.key_valid, 0);
      checkOutput("rst_code", kif.key_code, 0);
      checkOutput("rst_held", kif.key_held, 0);
      rst = 1'b1;
      for (int n = 0; n < 16; n++) begin
         checkOutput($sformatf("rotate_%0d", n), col, colOf((n / 4) % 4));
         step(1);
      end

      // Key "5" then the directed sequence 4 5 0 7 # * D.
      pressKey(5, "key5");
      for (int i = 0; i < 7; i++) pressKey(seq[i], $sformatf("seq%0d", i));

      // Bouncing contact on "1", then held low.
      base = pulse_cnt;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, (i % 2) == 0);
         step(3);
      end
      applyStimulus(0, 1'b1);
      waitPulse(base, lat);
      checkOutput("bounce_pulse", pulse_cnt, base + 1);
      checkOutput("bounce_code", last_code, 4'h1);
      applyStimulus(0, 1'b0);
      step(20);
      checkOutput("bounce_single", pulse_cnt, base + 1);

      // Short glitch must not register.
      base = pulse_cnt;
      k = $urandom_range(0, 15);
      applyStimulus(k, 1'b1);
      step(5);
      applyStimulus(k, 1'b0);
      step(40);
      checkOutput("glitch_no_pulse", pulse_cnt, base);
      checkOutput("glitch_held", kif.key_held, 0);

      // Two keys: "9" pressed while "2" is held is ignored.
      base = pulse_cnt;
      applyStimulus(1, 1'b1);
      waitPulse(base, lat);
      checkOutput("two_first_pulse", pulse_cnt, base + 1);
      checkOutput("two_first_code", last_code, 4'h2);
      applyStimulus(10, 1'b1);
      step(30);
      checkOutput("two_no_second", pulse_cnt, base + 1);
      checkOutput("two_held", kif.key_held, 1);
      applyStimulus(1, 1'b0);
      applyStimulus(10, 1'b0);
      step(40);
      checkOutput("two_after_release", pulse_cnt, base + 1);
      pressKey(10, "nine_clean");

      // Reset while waiting for release, with the key still held afterwards.
      k = $urandom_range(0, 15);
      base = pulse_cnt;
      applyStimulus(k, 1'b1);
      waitPulse(base, lat);
      checkOutput("rstwr_pulse", pulse_cnt, base + 1);
      step(3);
      rst = 1'b0;
      #1;
      checkOutput("rstwr_held", kif.key_held, 0);
      checkOutput("rstwr_valid", kif.key_valid, 0);
      checkOutput("rstwr_code", kif.key_code, 0);
      checkOutput("rstwr_col", col, 4'b1110);
      step(4);
      checkOutput("rstwr_no_pulse", pulse_cnt, base + 1);
      rst = 1'b1;
      base = pulse_cnt;
      waitPulse(base, lat);
      checkOutput("rstwr_fresh_pulse", pulse_cnt, base + 1);
      checkRange("rstwr_fresh_lat", lat, LAT_MIN, LAT_MAX);
      checkOutput("rstwr_fresh_code", last_code, code_tab[k]);
      applyStimulus(k, 1'b0);
      step(20);

      // Randomized keys.
      for (int i = 0; i < 6; i++) pressKey($urandom_range(0, 15), $sformatf("rnd%0d", i));

      checkOutput("pulse_width", wide_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
